// File: rtl/ndata_serializer_pkg.sv
// Shared definitions for the N-wide <-> narrow width converters.
// Holds the beat-holder state type, the index-width helper and the
// one-hot / lowest-set-bit functions reused by other width converters.
// Vectors up to MAX_VEC_W bits wide are supported by the helper functions.
package ndata_serializer_pkg;

    localparam int MAX_VEC_W = 64;

    // Beat holder: EMPTY waits for a beat, DRAIN is emitting its elements.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } beat_state_e;

    // Width of an element index; never below one bit so N==1 stays legal.
    function automatic int idx_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Isolates the lowest set bit of v (all zero when v is zero).
    function automatic logic [MAX_VEC_W-1:0] lsb_onehot(input logic [MAX_VEC_W-1:0] v);
        return v & (~v + MAX_VEC_W'(1));
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_single_bit(input logic [MAX_VEC_W-1:0] v);
        return (v != {MAX_VEC_W{1'b0}}) &&
               ((v & (v - MAX_VEC_W'(1))) == {MAX_VEC_W{1'b0}});
    endfunction

endpackage

// File: rtl/ndata_serializer_priority_encoder.sv
// Lowest-set-bit priority encoder: turns the remaining-element mask into a
// one-hot select, its binary index and an any-set flag.
// WIDTH must not exceed ndata_serializer_pkg::MAX_VEC_W.
module priority_encoder
    import ndata_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Pick the lowest requesting bit and encode its position.
    always_comb begin
        onehot = WIDTH'(lsb_onehot(MAX_VEC_W'(req)));
        idx    = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        any = (req != {WIDTH{1'b0}});
    end

endmodule

// File: rtl/ndata_serializer.sv
// Narrowing width converter: holds one N-element beat and emits its elements
// one per cycle, lowest index first, preserving packet framing on last.
// Optional feature macro: NDATA_SERIALIZER_SKIP_EN -- when defined, elements
// with keep=0 are skipped and an all-empty last beat becomes one keep=0 marker;
// when undefined, all N elements are emitted with their keep bits forwarded.
module ndata_serializer
    import ndata_serializer_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int NUM_ELEMENTS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_ELEMENTS*DATA_W-1:0] in_data,
    input  logic [NUM_ELEMENTS-1:0]        in_keep,
    input  logic                           in_last,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_keep,
    output logic                           out_last,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int N     = NUM_ELEMENTS;
    localparam int IDX_W = idx_w(N);

    beat_state_e             state_q, state_d;
    logic [N*DATA_W-1:0]     data_q, data_d;
    logic                    last_q, last_d;
    logic [N-1:0]            rem_q, rem_d;
`ifdef NDATA_SERIALIZER_SKIP_EN
    logic                    marker_q, marker_d;
    logic                    load_marker_s;
`else
    logic [N-1:0]            keep_q, keep_d;
`endif

    logic [N-1:0]            rem_onehot_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    rem_any_s;
    logic                    beat_vld_s;
    logic                    rem_single_s;
    logic                    out_fire_s;
    logic                    in_fire_s;
    logic [N-1:0]            load_rem_s;

    priority_encoder #(
        .WIDTH (N),
        .IDX_W (IDX_W)
    ) u_penc (
        .req    (rem_q),
        .onehot (rem_onehot_s),
        .idx    (idx_s),
        .any    (rem_any_s)
    );

    // Output element selection and both handshakes.
    always_comb begin
        beat_vld_s   = (state_q == ST_DRAIN);
        rem_single_s = is_single_bit(MAX_VEC_W'(rem_q));
        out_valid    = beat_vld_s && rem_any_s;
        out_data     = data_q[idx_s*DATA_W +: DATA_W];
        // The lowest remaining element is also the highest only when it is the last one left.
        out_last     = out_valid && last_q && rem_single_s;
`ifdef NDATA_SERIALIZER_SKIP_EN
        out_keep     = out_valid && !marker_q;
`else
        out_keep     = out_valid && keep_q[idx_s];
`endif
        out_fire_s   = out_valid && out_ready;
        // Taking the final element frees the register in the same edge: no bubble.
        in_ready     = !beat_vld_s || (out_fire_s && rem_single_s);
        in_fire_s    = in_valid && in_ready;
    end

    // Remaining-element mask to load for the incoming beat.
    always_comb begin
`ifdef NDATA_SERIALIZER_SKIP_EN
        load_marker_s = 1'b0;
        if (in_keep != {N{1'b0}}) begin
            load_rem_s = in_keep;
        end else if (in_last) begin
            // Empty last beat still closes the packet: emit element 0 flagged keep=0.
            load_rem_s    = N'(1'b1);
            load_marker_s = 1'b1;
        end else begin
            load_rem_s = {N{1'b0}};
        end
`else
        load_rem_s = {N{1'b1}};
`endif
    end

    // Beat holder next state: load on accept, retire one element per output transfer.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        last_d   = last_q;
        rem_d    = rem_q;
`ifdef NDATA_SERIALIZER_SKIP_EN
        marker_d = marker_q;
`else
        keep_d   = keep_q;
`endif
        case (state_q)
            ST_EMPTY, ST_DRAIN: begin
                if (in_fire_s) begin
                    data_d   = in_data;
                    last_d   = in_last;
                    rem_d    = load_rem_s;
`ifdef NDATA_SERIALIZER_SKIP_EN
                    marker_d = load_marker_s;
`else
                    keep_d   = in_keep;
`endif
                    // A beat with nothing to emit is dropped without occupying the register.
                    if (load_rem_s != {N{1'b0}}) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (out_fire_s) begin
                    rem_d = rem_q & ~rem_onehot_s;
                    if ((rem_q & ~rem_onehot_s) == {N{1'b0}}) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                rem_d   = {N{1'b0}};
            end
        endcase
    end

    // Beat register, mask and holder state; reset discards any partial beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            data_q   <= {(N*DATA_W){1'b0}};
            last_q   <= 1'b0;
            rem_q    <= {N{1'b0}};
`ifdef NDATA_SERIALIZER_SKIP_EN
            marker_q <= 1'b0;
`else
            keep_q   <= {N{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            last_q   <= last_d;
            rem_q    <= rem_d;
`ifdef NDATA_SERIALIZER_SKIP_EN
            marker_q <= marker_d;
`else
            keep_q   <= keep_d;
`endif
        end
    end

endmodule

// File: tb/tb_ndata_serializer.sv
// Self-checking bench for ndata_serializer (8-bit elements, N=4).
// A queue-based model predicts every output element and both handshakes;
// directed beats pin the model with literal expectations, then random beats
// under random backpressure, then a reset in the middle of a beat.
module tb_ndata_serializer;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_keep;
    logic           in_last;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_keep;
    logic           out_last;
    logic           out_valid;
    logic           out_ready;

    ndata_serializer #(.DATA_W(W), .NUM_ELEMENTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         k;
        logic         l;
        int           stamp;
    } elem_t;

    elem_t exp_q[$];
    elem_t got[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    rnd_ready = 1'b0;

    logic         stall_pend = 1'b0;
    logic [W-1:0] stall_d;
    logic         stall_k;
    logic         stall_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected output elements of one accepted beat.
    function automatic void model_accept(input logic [N*W-1:0] d, input logic [N-1:0] k, input logic l);
        elem_t e;
        e.stamp = 0;
`ifdef NDATA_SERIALIZER_SKIP_EN
        begin
            int hi;
            hi = -1;
            for (int i = 0; i < N; i++) if (k[i]) hi = i;
            if (hi < 0) begin
                if (l) begin
                    e.d = d[W-1:0]; e.k = 1'b0; e.l = 1'b1;
                    exp_q.push_back(e);
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (k[i]) begin
                        e.d = d[i*W +: W]; e.k = 1'b1; e.l = l && (i == hi);
                        exp_q.push_back(e);
                    end
                end
            end
        end
`else
        for (int i = 0; i < N; i++) begin
            e.d = d[i*W +: W]; e.k = k[i]; e.l = l && (i == N-1);
            exp_q.push_back(e);
        end
`endif
    endfunction

    always @(posedge clk) cyc++;

    // Backpressure driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: checks handshakes and every transferred element against the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_pend = 1'b0;
        end else begin
            logic exp_rdy;
            exp_rdy = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
            check("out_valid", out_valid, exp_q.size() != 0);
            check("in_ready", in_ready, exp_rdy);
            if (stall_pend) begin
                check("stall_data", out_data, stall_d);
                check("stall_keep", out_keep, stall_k);
                check("stall_last", out_last, stall_l);
            end
            if (out_valid && out_ready) begin
                elem_t g;
                g.d = out_data; g.k = out_keep; g.l = out_last; g.stamp = cyc;
                got.push_back(g);
                if (exp_q.size() != 0) begin
                    elem_t e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_keep", out_keep, e.k);
                    check("out_last", out_last, e.l);
                end
            end
            stall_pend = out_valid && !out_ready;
            stall_d = out_data; stall_k = out_keep; stall_l = out_last;
            if (in_valid && exp_rdy) model_accept(in_data, in_keep, in_last);
        end
    end

    task automatic drive(input logic [N*W-1:0] d, input logic [N-1:0] k, input logic l);
        bit acc;
        int waited;
        in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
        acc = 1'b0;
        waited = 0;
        while (!acc && waited < 60) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b [4];
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0; out_ready = 1'b1;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_keep", out_keep, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // T1: full beat, elements lowest first, last only on the final one.
        got.delete();
        drive(32'h44332211, 4'b1111, 1'b1);
        idle(8);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        check("t1_count", got.size(), 4);
        if (got.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_data", got[i].d, exp_b[i]);
                check("t1_keep", got[i].k, 1'b1);
                check("t1_last", got[i].l, i == 3);
            end
        end

        // T2: two beats back to back, 8 outputs in 8 consecutive cycles.
        got.delete();
        drive(32'h44332211, 4'b1111, 1'b0);
        drive(32'h88776655, 4'b1111, 1'b1);
        idle(10);
        check("t2_count", got.size(), 8);
        if (got.size() == 8) begin
            check("t2_span", got[7].stamp - got[0].stamp, 7);
            check("t2_data7", got[7].d, 8'h88);
        end

        // T3: sparse keep, then an empty non-last beat, then a full beat.
        got.delete();
        drive(32'h44332211, 4'b1010, 1'b1);
        drive(32'h88776655, 4'b0000, 1'b0);
        drive(32'hDDCCBBAA, 4'b1111, 1'b0);
        idle(12);
`ifdef NDATA_SERIALIZER_SKIP_EN
        check("t3_count", got.size(), 6);
        if (got.size() == 6) begin
            check("t3_d0", got[0].d, 8'h22);
            check("t3_l0", got[0].l, 1'b0);
            check("t3_d1", got[1].d, 8'h44);
            check("t3_l1", got[1].l, 1'b1);
            check("t3_k1", got[1].k, 1'b1);
            check("t3_d2", got[2].d, 8'hAA);
        end
`else
        check("t3_count", got.size(), 12);
        if (got.size() == 12) begin
            check("t3_k0", got[0].k, 1'b0);
            check("t3_k1", got[1].k, 1'b1);
            check("t3_l3", got[3].l, 1'b1);
            check("t3_d4", got[4].d, 8'h55);
            check("t3_k4", got[4].k, 1'b0);
            check("t3_d8", got[8].d, 8'hAA);
        end
`endif

        // T4: empty last beat (compacting build) / keep forwarding (full build).
        got.delete();
`ifdef NDATA_SERIALIZER_SKIP_EN
        drive(32'h44332211, 4'b0000, 1'b1);
        idle(6);
        check("t4_count", got.size(), 1);
        if (got.size() == 1) begin
            check("t4_data", got[0].d, 8'h11);
            check("t4_keep", got[0].k, 1'b0);
            check("t4_last", got[0].l, 1'b1);
        end
`else
        drive(32'h44332211, 4'b0110, 1'b1);
        idle(8);
        check("t4_count", got.size(), 4);
        if (got.size() == 4) begin
            check("t4_k0", got[0].k, 1'b0);
            check("t4_k1", got[1].k, 1'b1);
            check("t4_k2", got[2].k, 1'b1);
            check("t4_k3", got[3].k, 1'b0);
            check("t4_l3", got[3].l, 1'b1);
        end
`endif

        // T5: random beats under 50% backpressure.
        rnd_ready = 1'b1;
        for (int b = 0; b < 1000; b++) begin
            drive($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rnd_ready = 1'b0;
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) idle(1);
        check("t5_drained", exp_q.size(), 0);
        idle(2);

        // T6: reset during the 2nd element of a beat.
        got.delete();
        drive(32'h44332211, 4'b1111, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_in_ready", in_ready, 1'b1);
        check("t6_out_last", out_last, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(6);
        check("t6_count", got.size(), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
